// File: rtl/hazard_ctrl.sv
// ID-stage hazard/stall controller: load-use bubbles, branch flushes, memory freeze, watchdog.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined; otherwise they read 0.
module hazard_ctrl #(
  parameter int unsigned WAIT_W  = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [6:0]  IFID_opcode_i,
  input  logic [4:0]  IFID_rs1_i,
  input  logic [4:0]  IFID_rs2_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_rd_i,
  input  logic        branch_taken_i,
  input  logic        mem_stall_i,
  output logic        NoOp_o,
  output logic        PCWrite_o,
  output logic        IFID_Write_o,
  output logic        Flush_o,
  output logic        Freeze_o,
  output logic        timeout_o,
  output logic [31:0] lu_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] wait_cnt_o
);

  typedef enum logic [1:0] {StHalt, StRun, StMemWait} state_e;

  localparam logic [WAIT_W-1:0] TimeoutVal = WAIT_W'(TIMEOUT);

  state_e            stateQ, stateD;
  logic              useRs1, useRs2, loadUse, active, stallActive;
  logic [WAIT_W-1:0] waitQ, waitD;
  logic              timeoutQ;

  always_comb begin
    useRs1 = 1'b0;
    useRs2 = 1'b0;
    unique case (IFID_opcode_i)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        useRs1 = 1'b1;
        useRs2 = 1'b1;
      end
      7'b0010011, 7'b0000011: useRs1 = 1'b1;
      default: ;
    endcase
  end

  assign loadUse = IDEX_MemRead_i && (IDEX_rd_i != 5'd0) &&
                   ((useRs1 && (IDEX_rd_i == IFID_rs1_i)) ||
                    (useRs2 && (IDEX_rd_i == IFID_rs2_i)));

  assign active      = (stateQ != StHalt);
  assign stallActive = active && mem_stall_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) stateQ <= StHalt;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StHalt:    if (start_i) stateD = StRun;
      StRun:     if (mem_stall_i) stateD = StMemWait;
      StMemWait: if (!mem_stall_i) stateD = StRun;
      default:   stateD = StHalt;
    endcase
  end

  // MEM_WAIT without a stall behaves exactly like RUN in the same cycle.
  always_comb begin
    NoOp_o       = 1'b0;
    PCWrite_o    = 1'b0;
    IFID_Write_o = 1'b0;
    Flush_o      = 1'b0;
    Freeze_o     = 1'b0;
    unique case (stateQ)
      StRun, StMemWait: begin
        if (mem_stall_i) begin
          Freeze_o = 1'b1;
        end else if (loadUse) begin
          NoOp_o = 1'b1;
        end else begin
          PCWrite_o    = 1'b1;
          IFID_Write_o = 1'b1;
          Flush_o      = branch_taken_i;
        end
      end
      default: NoOp_o = 1'b1;
    endcase
  end

  always_comb begin
    waitD = '0;
    if (stallActive) waitD = (&waitQ) ? waitQ : waitQ + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      waitQ    <= '0;
      timeoutQ <= 1'b0;
    end else begin
      waitQ <= waitD;
      if (stallActive && (waitD == TimeoutVal)) timeoutQ <= 1'b1;
    end
  end

  assign timeout_o = timeoutQ;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] luCntQ, flushCntQ, waitCntQ;

  function automatic logic [31:0] satInc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      luCntQ    <= '0;
      flushCntQ <= '0;
      waitCntQ  <= '0;
    end else begin
      luCntQ    <= satInc(luCntQ, active && !mem_stall_i && loadUse);
      flushCntQ <= satInc(flushCntQ, Flush_o);
      waitCntQ  <= satInc(waitCntQ, Freeze_o);
    end
  end

  assign lu_cnt_o    = luCntQ;
  assign flush_cnt_o = flushCntQ;
  assign wait_cnt_o  = waitCntQ;
`else
  assign lu_cnt_o    = 32'd0;
  assign flush_cnt_o = 32'd0;
  assign wait_cnt_o  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (TIMEOUT=4); counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [6:0]  IFID_opcode_i;
  logic [4:0]  IFID_rs1_i, IFID_rs2_i, IDEX_rd_i;
  logic        IDEX_MemRead_i, branch_taken_i, mem_stall_i;
  logic        NoOp_o, PCWrite_o, IFID_Write_o, Flush_o, Freeze_o, timeout_o;
  logic [31:0] lu_cnt_o, flush_cnt_o, wait_cnt_o;

  int nCmp = 0;
  int nErr = 0;

  hazard_ctrl #(.WAIT_W(8), .TIMEOUT(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .IFID_opcode_i  (IFID_opcode_i),
    .IFID_rs1_i     (IFID_rs1_i),
    .IFID_rs2_i     (IFID_rs2_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_rd_i      (IDEX_rd_i),
    .branch_taken_i (branch_taken_i),
    .mem_stall_i    (mem_stall_i),
    .NoOp_o         (NoOp_o),
    .PCWrite_o      (PCWrite_o),
    .IFID_Write_o   (IFID_Write_o),
    .Flush_o        (Flush_o),
    .Freeze_o       (Freeze_o),
    .timeout_o      (timeout_o),
    .lu_cnt_o       (lu_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
    .wait_cnt_o     (wait_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkOut(input string tag, input logic noop, input logic pcw, input logic ifw,
                          input logic flush, input logic freeze);
    checkVal({tag, ".noop"}, 32'(NoOp_o), 32'(noop));
    checkVal({tag, ".pcw"}, 32'(PCWrite_o), 32'(pcw));
    checkVal({tag, ".ifw"}, 32'(IFID_Write_o), 32'(ifw));
    checkVal({tag, ".flush"}, 32'(Flush_o), 32'(flush));
    checkVal({tag, ".freeze"}, 32'(Freeze_o), 32'(freeze));
  endtask

  task automatic checkCnt(input string tag, input int lu, input int fl, input int wt);
    checkVal({tag, ".lu_cnt"}, lu_cnt_o, PerfEn ? 32'(lu) : 32'd0);
    checkVal({tag, ".flush_cnt"}, flush_cnt_o, PerfEn ? 32'(fl) : 32'd0);
    checkVal({tag, ".wait_cnt"}, wait_cnt_o, PerfEn ? 32'(wt) : 32'd0);
  endtask

  // Advance one clock; inputs change and checks run 1-2 ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic setId(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic mr, input logic [4:0] rd, input logic bt);
    IFID_opcode_i  = op;
    IFID_rs1_i     = rs1;
    IFID_rs2_i     = rs2;
    IDEX_MemRead_i = mr;
    IDEX_rd_i      = rd;
    branch_taken_i = bt;
    #1;
  endtask

  localparam logic [6:0] OpR = 7'b0110011, OpI = 7'b0010011, OpBeq = 7'b1100011;
  localparam logic [6:0] OpSw = 7'b0100011, OpNop = 7'b0000000;

  initial begin
    rst_i = 1'b0;
    start_i = 1'b0;
    mem_stall_i = 1'b0;
    setId(OpNop, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checkOut("reset", 1, 0, 0, 0, 0);
    checkVal("reset.timeout", 32'(timeout_o), 32'd0);
    checkCnt("reset", 0, 0, 0);
    tick();
    rst_i = 1'b1;
    #1;

    // Load-use and a taken branch presented in HALT must not leak through.
    setId(OpR, 5'd5, 5'd7, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOut("halt", 1, 0, 0, 0, 0);
      tick();
    end
    start_i = 1'b1;
    #1;
    checkOut("start_cycle", 1, 0, 0, 0, 0);
    tick();
    start_i = 1'b0;
    setId(OpNop, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    checkOut("run", 0, 1, 1, 0, 0);
    checkCnt("run", 0, 0, 0);

    setId(OpR, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0);
    checkOut("lu_add", 1, 0, 0, 0, 0);
    tick();
    checkCnt("after_lu_add", 1, 0, 0);
    setId(OpR, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0);
    checkOut("lu_rd0", 0, 1, 1, 0, 0);
    tick();
    setId(OpI, 5'd7, 5'd5, 1'b1, 5'd5, 1'b0);
    checkOut("addi_rs2field", 0, 1, 1, 0, 0);
    tick();
    setId(OpSw, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0);
    checkOut("lu_sw_rs2", 1, 0, 0, 0, 0);
    tick();
    setId(OpNop, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0);
    checkOut("nop_nouse", 0, 1, 1, 0, 0);
    tick();

    setId(OpBeq, 5'd5, 5'd6, 1'b1, 5'd5, 1'b1);
    checkOut("beq_lu", 1, 0, 0, 0, 0);
    tick();
    setId(OpBeq, 5'd5, 5'd6, 1'b0, 5'd5, 1'b1);
    checkOut("beq_taken", 0, 1, 1, 1, 0);
    tick();
    checkCnt("after_beq", 3, 1, 0);

    setId(OpR, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0);
    mem_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOut("freeze", 0, 0, 0, 0, 1);
      tick();
    end
    mem_stall_i = 1'b0;
    #1;
    checkOut("release_bubble", 1, 0, 0, 0, 0);
    checkVal("release.timeout", 32'(timeout_o), 32'd0);
    tick();
    checkCnt("after_freeze", 4, 1, 3);

    setId(OpNop, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    mem_stall_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checkVal($sformatf("wdog_edge%0d", k), 32'(timeout_o), (k >= 4) ? 32'd1 : 32'd0);
    end
    mem_stall_i = 1'b0;
    #1;
    checkOut("wdog_release", 0, 1, 1, 0, 0);
    tick();
    checkVal("wdog_sticky", 32'(timeout_o), 32'd1);
    checkCnt("after_wdog", 4, 1, 9);

    // Short stall, then reset mid-MEM_WAIT, away from the clock edge.
    mem_stall_i = 1'b1;
    tick();
    tick();
    #1;
    rst_i = 1'b0;
    #1;
    checkOut("reset_midwait", 1, 0, 0, 0, 0);
    checkVal("reset_midwait.timeout", 32'(timeout_o), 32'd0);
    checkCnt("reset_midwait", 0, 0, 0);
    tick();
    rst_i = 1'b1;
    mem_stall_i = 1'b0;
    #1;
    checkOut("post_reset_halt", 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench time limit reached");
    $fatal(1);
  end

endmodule
